// File: rtl/inst_trace_fifo.sv
// -----------------------------------------------------------------------------
// inst_trace_fifo
//
// Capture buffer for retired instructions in the debug/trace path. Writeback
// presents one {PC, instruction} per cycle. The block stores these entries in a
// circular FIFO and hands them out one at a time over a valid/ready handshake.
//
// A PC-match trigger freezes the buffer post_cnt_i entries after the trigger
// entry. The instructions around the trigger then stay in the buffer, and the
// consumer can drain them at its own pace.
//
// Optional feature macro: TRACE_SKIP_NOP_EN
//   When defined, a capture with cap_inst_i == 0 is ignored completely. It is
//   not pushed, not counted as a drop, cannot fire the trigger, and does not
//   decrement the post-trigger counter.
//
// Ports
//   clk, rst_n     single clock; asynchronous active-low reset
//   cap_valid_i    retired instruction present this cycle
//   cap_pc_i       PC of the retired instruction
//   cap_inst_i     raw instruction word
//   trig_en_i      arms PC-match triggering
//   trig_pc_i      trigger PC
//   post_cnt_i     entries to capture after the trigger entry before freezing
//   clear_i        synchronous clear: empty FIFO, zero drop count, back to RUN
//   out_valid_o    head entry available
//   out_ready_i    consumer accepts the head this cycle
//   out_pc_o       head PC (zero when empty)
//   out_inst_o     head instruction (zero when empty)
//   count_o        current occupancy, 0..DEPTH
//   frozen_o       buffer frozen after a trigger
//   drop_cnt_o     captures lost to a full FIFO; saturates at 16'hFFFF
// -----------------------------------------------------------------------------
module inst_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cap_valid_i,
  input  logic [31:0]      cap_pc_i,
  input  logic [31:0]      cap_inst_i,
  input  logic             trig_en_i,
  input  logic [31:0]      trig_pc_i,
  input  logic [7:0]       post_cnt_i,
  input  logic             clear_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      out_pc_o,
  output logic [31:0]      out_inst_o,
  output logic [CNT_W-1:0] count_o,
  output logic             frozen_o,
  output logic [15:0]      drop_cnt_o
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_POST   = 2'd1,
    ST_FROZEN = 2'd2
  } state_e;

  state_e           state_q;
  logic [7:0]       remain_q;
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic [15:0]      drop_q, drop_d;

  logic [31:0] pc_mem   [DEPTH];
  logic [31:0] inst_mem [DEPTH];

  logic is_nop, cap_ok, full, pop, push, drop, trig_hit;

`ifdef TRACE_SKIP_NOP_EN
  assign is_nop = (cap_inst_i == 32'h0);
`else
  assign is_nop = 1'b0;
`endif

  // NOTE: every signal assigned in always_comb gets a default value first,
  // so no path can leave it unassigned and infer a latch.
  always_comb begin
    full     = (count_q == CNT_W'(DEPTH));
    cap_ok   = cap_valid_i && !is_nop && (state_q != ST_FROZEN) && !clear_i;
    pop      = out_valid_o && out_ready_i && !clear_i;
    // A pop in the same cycle makes room, even when the FIFO is full.
    push     = cap_ok && (!full || pop);
    drop     = cap_ok && full && !pop;
    // A matching capture is a trigger only if it is accepted. PC matches are
    // ignored outside RUN.
    trig_hit = push && (state_q == ST_RUN) && trig_en_i && (cap_pc_i == trig_pc_i);

    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    drop_d = drop_q;
    if (drop && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
  end

  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples the values that existed before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
    end else if (clear_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap by natural overflow.
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      drop_q  <= drop_d;
    end
  end

  // NOTE: the storage array has no reset. Entries are only observed once
  // count_q says they were written, so resetting them would buy nothing.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]   <= cap_pc_i;
      inst_mem[wr_ptr_q] <= cap_inst_i;
    end
  end

  // Trigger state machine. remain_q counts the entries still to be captured
  // after the trigger entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      remain_q <= '0;
    end else if (clear_i) begin
      state_q  <= ST_RUN;
      remain_q <= '0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (trig_hit) begin
            if (post_cnt_i == 8'd0) begin
              state_q <= ST_FROZEN;
            end else begin
              state_q  <= ST_POST;
              remain_q <= post_cnt_i;
            end
          end
        end
        ST_POST: begin
          if (push) begin
            remain_q <= remain_q - 8'd1;
            if (remain_q == 8'd1) state_q <= ST_FROZEN;
          end
        end
        ST_FROZEN: ;
        default: state_q <= ST_RUN;
      endcase
    end
  end

  // The head is gated by occupancy. The outputs therefore read zero when the
  // FIFO is empty, including right after an asynchronous reset.
  assign out_valid_o = (count_q != '0);
  assign out_pc_o    = out_valid_o ? pc_mem[rd_ptr_q]   : 32'h0;
  assign out_inst_o  = out_valid_o ? inst_mem[rd_ptr_q] : 32'h0;
  assign count_o     = count_q;
  assign frozen_o    = (state_q == ST_FROZEN);
  assign drop_cnt_o  = drop_q;

endmodule

// File: doc/inst_trace_fifo.md
# inst_trace_fifo

Capture buffer for retired instructions. Sits directly upstream of the instruction disassembler in the debug/trace path: writeback presents one retired {PC, instruction} per cycle, this block buffers them in a FIFO, and it presents them one at a time over a valid/ready handshake. A PC-match trigger freezes the buffer a programmable number of entries after a chosen instruction retires, so the instructions around it are kept for inspection.

## Interface
- `DEPTH`, 16: FIFO entries. Power of two, 4 to 256.
- `CNT_W`, `$clog2(DEPTH)+1`: width of `count`.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cap_valid`  in  1  a retired instruction is present this cycle.
- `cap_pc`  in  32  PC of the retired instruction.
- `cap_inst`  in  32  raw instruction word.
- `trig_en`  in  1  arms PC-match triggering.
- `trig_pc`  in  32  trigger PC.
- `post_cnt`  in  8  entries to capture after the trigger entry before freezing.
- `clear`  in  1  synchronous: empties the FIFO, zeroes `drop_cnt`, returns to RUN.
- `out_valid`  out  1  head entry available.
- `out_ready`  in  1  consumer accepts the head this cycle.
- `out_pc`  out  32  head PC.
- `out_inst`  out  32  head instruction; drives the disassembler `inst` input.
- `count`  out  CNT_W  current occupancy, 0..DEPTH.
- `frozen`  out  1  state is FROZEN.
- `drop_cnt`  out  16  captures lost because the FIFO was full; saturates at 16'hFFFF.

## Operation
- Storage: circular array plus rd/wr pointers; `count` is held as its own register.
- Push condition: `cap_valid` && state != FROZEN && (count < DEPTH || pop).
- Pop condition: `out_valid && out_ready`.
- Push and pop in the same cycle, including when full: both happen and `count` is unchanged.
- Rejected push (`cap_valid`, not FROZEN, full, no pop): entry is discarded and `drop_cnt` increments.
- FSM states:
  - RUN: captures normally. A pushed entry with `trig_en` && `cap_pc == trig_pc` is the trigger entry. Trigger entry with `post_cnt == 0` → FROZEN. Otherwise → POST with `remain = post_cnt`.
  - POST: each pushed entry decrements `remain`. The push that takes `remain` from 1 to 0 → FROZEN. PC matches are ignored in POST.
  - FROZEN: no pushes and no drop counting. Popping continues, so the consumer can drain the buffer.
  - `clear` from any state → RUN, `count=0`, pointers 0, `remain=0`, `drop_cnt=0`. `clear` has priority over any push or pop in the same cycle.
- A trigger match on a dropped (rejected) capture is not a trigger.
- Pointers wrap modulo DEPTH.

## Timing
- Reset values: `out_valid=0`, `count=0`, `frozen=0`, `drop_cnt=0`, `out_pc=0`, `out_inst=0`, state RUN, pointers 0.
- Push-to-output latency is 1 cycle: an entry pushed at edge N into an empty FIFO gives `out_valid=1` after edge N. No same-cycle bypass.
- `out_pc` and `out_inst` come from the head entry and stay stable while `out_valid && !out_ready`.
- `frozen` asserts in the cycle after the edge that pushes the final entry.
- `rst_n` falling mid-operation clears everything immediately; buffered entries are lost.

## Configuration
- `TRACE_SKIP_NOP_EN` defined: captures with `cap_inst == 32'h0` are neither pushed nor counted as drops. They do not fire the trigger and do not decrement `remain`.
- Not defined: NOPs are buffered like any other instruction.

## Test plan
- Reset, then 3 captures (PC 0x100/0x104/0x108), `out_ready=0` → `count=3`, head shows PC 0x100. Raise `out_ready` → PCs appear in order, `out_valid` drops after the third pop.
- Fill DEPTH=16 entries, then 2 more captures with `out_ready=0` → `count=16`, `drop_cnt=2`. Capture plus pop together while full → accepted, `count` stays 16.
- `trig_pc=0x200`, `post_cnt=2`, captures 0x1F8..0x210 → buffer ends with 0x200, 0x204, 0x208. `frozen=1`. Later captures ignored, `drop_cnt` unchanged.
- `post_cnt=0` with a trigger match → FROZEN right after the trigger entry. `clear` → `count=0`, `frozen=0`, `drop_cnt=0`.
- `TRACE_SKIP_NOP_EN` defined, captures inst 0x0, 0x24020001, 0x0 → `count=1`. Undefined → `count=3`.
- Assert `rst_n=0` mid-drain with 5 entries buffered → all outputs at reset values asynchronously, before the next clock edge.
